// File: rtl/sha256_pkg.sv
// sha256_pkg: shared feeder state encodings, chunk constants and the byteswap helper.
// Ports: none (package imported by the feeder, its chunk buffer and the core's dat_msb_i swap).
package sha256_pkg;

    localparam int         CHUNK_WORDS = 16;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef enum logic [2:0] {IDLE, FILL, PAD, SEND, BUSY, DONE} feed_state_t;

    // Reverses byte order; turns a big-endian length half into LSB-first byte order.
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_msg_feeder_if.sv
// sha256_msg_feeder_if: message stream input plus the sha256 core load/status port.
// Ports: s_valid/s_ready/s_data/s_last/s_bytes (byte-granular word stream),
//        dat_vaild_o/dat_lsb_o (core load port), hash_vaild_i (core idle/digest valid),
//        msg_done_o (whole-message digest valid pulse).
// master = message source and core side, slave = the feeder.
interface sha256_msg_feeder_if;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [2:0]  s_bytes;
    logic        dat_vaild_o;
    logic [31:0] dat_lsb_o;
    logic        hash_vaild_i;
    logic        msg_done_o;

    modport master (
        output s_valid, s_data, s_last, s_bytes, hash_vaild_i,
        input  s_ready, dat_vaild_o, dat_lsb_o, msg_done_o
    );

    modport slave (
        input  s_valid, s_data, s_last, s_bytes, hash_vaild_i,
        output s_ready, dat_vaild_o, dat_lsb_o, msg_done_o
    );

endinterface

// File: rtl/sha256_chunk_buf.sv
// sha256_chunk_buf: 16x32 register file holding one 512-bit chunk.
// Ports: clk, rst_n (async active-low), clr (sync clear of all words),
//        we/waddr/wdata (write port), raddr/rdata (combinational read port).
module sha256_chunk_buf
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [CHUNK_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHUNK_WORDS; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < CHUNK_WORDS; i++)
                if (clr) mem[i] <= '0;
                else if (we && waddr == 4'(i)) mem[i] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sha256_msg_feeder.sv
// sha256_msg_feeder: buffers a byte-granular message into 512-bit chunks, appends
// SHA-256 padding and length, and feeds the sha256 core in contiguous 16-word bursts.
// Ports: clk, rst_n (async active-low), bus (sha256_msg_feeder_if.slave: message
//        stream in, core load port out, core status in, msg_done_o pulse out).
module sha256_msg_feeder
    import sha256_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_msg_feeder_if.slave   bus
);

    feed_state_t state;
    logic [4:0]  idx;           // bit 4 set means the chunk is complete
    logic [60:0] len_bytes;
    logic        pad_done;      // 0x80 terminator already placed
    logic        len_pending;   // length did not fit; one more chunk follows
    logic        tail;          // s_last has been accepted
    logic        core_ack;      // core dropped hash_vaild_i since this burst began
    logic        full, accept, go_send, we;
    logic [2:0]  nbytes;
    logic [31:0] last_word, pad_word, len_word, wdata, rdata;
    logic [63:0] bitlen;

    assign full     = idx[4];
    assign bus.s_ready = (state == IDLE) || (state == FILL && !full);
    assign accept   = bus.s_valid && bus.s_ready;
    assign go_send  = full && (state == FILL || state == PAD) && bus.hash_vaild_i;
    assign nbytes   = bus.s_bytes[2] ? 3'd4 : bus.s_bytes;
    assign bitlen   = {len_bytes, 3'b000};
    assign len_word = idx[0] ? bswap(bitlen[31:0]) : bswap(bitlen[63:32]);
    assign pad_word = !pad_done ? {24'h0, PAD_BYTE} :
                      (len_pending || idx < 5'd14) ? 32'h0 : len_word;
    assign we       = (state == PAD) ? !full : accept;
    assign wdata    = (state == PAD) ? pad_word : bus.s_last ? last_word : bus.s_data;

    // Tail word: keep the valid low bytes, terminator right after them, zeros above.
    always_comb begin
        last_word = bus.s_data;
        for (int k = 0; k < 4; k++)
            if (k == int'(nbytes)) last_word[8*k +: 8] = PAD_BYTE;
            else if (k > int'(nbytes)) last_word[8*k +: 8] = 8'h00;
    end

    sha256_chunk_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == DONE),
        .we    (we),
        .waddr (idx[3:0]),
        .wdata (wdata),
        .raddr (idx[3:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            len_bytes       <= '0;
            pad_done        <= 1'b0;
            len_pending     <= 1'b0;
            tail            <= 1'b0;
            core_ack        <= 1'b0;
            bus.dat_vaild_o <= 1'b0;
            bus.dat_lsb_o   <= '0;
            bus.msg_done_o  <= 1'b0;
        end else begin
            bus.dat_vaild_o <= 1'b0;
            bus.dat_lsb_o   <= '0;
            bus.msg_done_o  <= 1'b0;
            if (go_send) begin
                state    <= SEND;
                idx      <= '0;
                core_ack <= 1'b0;
            end else begin
                case (state)
                    IDLE, FILL: if (accept) begin
                        idx         <= idx + 5'd1;
                        state       <= bus.s_last ? PAD : FILL;
                        len_bytes   <= (state == IDLE ? 61'd0 : len_bytes) +
                                       61'(bus.s_last ? nbytes : 3'd4);
                        tail        <= bus.s_last;
                        pad_done    <= bus.s_last && !nbytes[2];
                        len_pending <= bus.s_last && !nbytes[2] && idx >= 5'd14;
                    end
                    PAD: if (!full) begin
                        idx <= idx + 5'd1;
                        if (!pad_done) begin
                            pad_done    <= 1'b1;
                            len_pending <= idx >= 5'd14;
                        end
                    end
                    SEND: begin
                        bus.dat_vaild_o <= 1'b1;
                        bus.dat_lsb_o   <= rdata;
                        idx             <= idx + 5'd1;
                        if (!bus.hash_vaild_i) core_ack <= 1'b1;
                        if (idx == 5'(CHUNK_WORDS - 1)) state <= BUSY;
                    end
                    BUSY: begin
                        if (!bus.hash_vaild_i) core_ack <= 1'b1;
                        else if (core_ack) begin
                            idx            <= '0;
                            len_pending    <= 1'b0;
                            // A full final chunk without terminator also needs a PAD chunk.
                            state          <= !tail ? FILL :
                                              (len_pending || !pad_done) ? PAD : DONE;
                            bus.msg_done_o <= tail && !len_pending && pad_done;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sha256_msg_feeder.md
# sha256_msg_feeder

Front-end initiator for the `sha256` core. It accepts a byte-granular message as a stream of 32-bit words and buffers each 512-bit chunk. It appends SHA-256 padding (0x80, zeros, 64-bit bit length) and drives the core's `dat_vaild_i`/`dat_lsb_i` load port with contiguous 16-word bursts, paced by the core's `hash_vaild_o`. When the core finishes the last chunk, the feeder pulses `msg_done_o`.

## Interface
- `CHUNK_WORDS`, 16: words per chunk. Fixed by SHA-256; not intended for override.
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous active-low reset. Also resets the `sha256` core.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: input word accepted when `s_valid & s_ready`.
- `s_data` in 32: message bytes, LSB-first. Byte k of the word is `s_data[8k+7:8k]`, k=0 is earliest.
- `s_last` in 1: final word of the message.
- `s_bytes` in 3: valid bytes in the final word, 0..4, sampled only with `s_last`. Bytes occupy the low positions. `s_bytes=0` with `s_last` is the empty-tail case.
- `dat_vaild_o` out 1: drives the core's `dat_vaild_i`.
- `dat_lsb_o` out 32: drives the core's `dat_lsb_i`, in the same LSB-first byte order.
- `hash_vaild_i` in 1: the core's `hash_vaild_o` (core idle / digest valid).
- `msg_done_o` out 1: one-cycle pulse when the digest of the whole message is valid on the core outputs.

## Operation
- Buffer: 16x32 chunk RAM (registers), a 4-bit write index, a 61-bit byte counter `len_bytes`, and flags `pad_done` and `len_pending`.
- States: IDLE, FILL, PAD, SEND, BUSY, DONE.
- **IDLE**
  - `s_ready=1`.
  - The first accepted word clears `len_bytes`, writes index 0 and enters FILL.
- **FILL**
  - `s_ready=1`.
  - Each accepted word is written at the index; the index increments.
  - Non-last words add 4 to `len_bytes`.
  - Index reaching 16 with `s_last` not yet seen: go to SEND.
  - On an accepted `s_last` word:
    - add `s_bytes` to `len_bytes`;
    - if `s_bytes<4`, write 0x80 into byte `s_bytes` of that word and zero the higher bytes; set `pad_done`;
    - go to PAD.
- **PAD**
  - `s_ready=0`. Fills the remaining words, one word per cycle.
  - If `pad_done` is clear, write word 0x00000080 and set `pad_done`.
  - Otherwise write zeros up to index 13.
  - If the index is ≤14 after the 0x80 word: write the length into words 14 and 15, then go to SEND.
    - Word 14 = byteswap(`bitlen[63:32]`).
    - Word 15 = byteswap(`bitlen[31:0]`).
    - `bitlen = {len_bytes,3'b000}`, taken modulo 2^64.
  - If the 0x80 word landed at index 14 or 15: zero-fill to 16, set `len_pending`, go to SEND. The next chunk is all zeros plus the length words.
- **SEND**
  - Entered only when `hash_vaild_i=1`; otherwise the feeder holds in the previous state with the buffer complete.
  - Outputs words 0..15 on 16 consecutive cycles with `dat_vaild_o=1`. No gaps are allowed.
  - Then goes to BUSY.
- **BUSY**
  - Waits for `hash_vaild_i` to return to 1.
  - Then:
    - message incomplete: go to FILL;
    - `len_pending`: build a length-only chunk via PAD;
    - otherwise: go to DONE.
- **DONE**
  - `msg_done_o=1` for 1 cycle, then IDLE.
- Core hash re-initialisation between messages is outside this block.
- `s_valid` gaps in FILL only stall buffering. Bursts to the core stay contiguous.

## Timing
- Reset values:
  - state IDLE;
  - `dat_vaild_o=0`, `dat_lsb_o=0`, `msg_done_o=0`;
  - `s_ready=1` (IDLE decode);
  - buffer, counters and flags cleared.
- `dat_vaild_o` and `dat_lsb_o` are registered. The first burst word appears 1 cycle after SEND entry.
- There is at least 1 cycle with `dat_vaild_o=0` between bursts, because the core clears its counter in IDLE.
- `msg_done_o` fires 1 cycle after BUSY sees `hash_vaild_i=1` on the final chunk.
- Reset mid-burst aborts the message. No partial state survives, and `dat_vaild_o` drops asynchronously.
- An `s_last` word that fills index 15 with `s_bytes=4`: PAD starts a fresh chunk with 0x80 at word 0.

## Structure
- Shared `sha256_pkg` holds:
  - state encodings;
  - `CHUNK_WORDS`;
  - `PAD_BYTE=8'h80`;
  - the byteswap function, shared with the core's `dat_msb_i` swap.
- One sub-module, `sha256_chunk_buf`: the 16x32 register file with write port, read port and clear.

## Test plan
- **"abc":** `s_data=32'h00636261`, `s_bytes=3`, `s_last`.
  - Burst: w0=0x80636261, w1..w14=0, w15=0x18000000.
  - Core digest ba7816bf…f20015ad; `msg_done_o` pulses once.
- **Empty message:** `s_last`, `s_bytes=0`.
  - w0=0x00000080, w15=0.
  - Digest e3b0c442…7852b855.
- **55 bytes:** 13 full words plus `s_bytes=3`.
  - Single chunk; w13 has byte3=0x80.
  - w14=0, w15=0xB8010000.
- **56 bytes:** 14 full words.
  - Chunk1 w14=0x00000080, w15=0.
  - Chunk2 all zero except w15=0xC0010000.
  - Exactly 2 bursts.
- **Stall:** `s_valid` toggling randomly during a 64-byte message.
  - Every burst has `dat_vaild_o` high for exactly 16 contiguous cycles.
  - `s_ready=0` throughout SEND and BUSY.
- **Reset at burst word 7:**
  - All outputs return to reset values.
  - A subsequent "abc" message produces the correct digest.
